// File: rtl/serial_eq_arbiter_pkg.sv
// Shared types and sizing helpers for the serial equality arbiter.
package serial_eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_nsteps(input int width, input int bits_per_cycle);
    return width / bits_per_cycle;
  endfunction

  // Step counter never narrower than one bit, even for a single-step compare.
  function automatic int calc_cntw(input int nsteps);
    return (nsteps <= 1) ? 1 : $clog2(nsteps);
  endfunction

endpackage

// File: rtl/serial_eq_arbiter_eq_slice_cmp.sv
// Narrow equality slice: per-bit XNOR AND-reduced to a single match bit.
module eq_slice_cmp #(
  parameter int W = 2
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq
);

  assign o_eq = &(i_a ~^ i_b);

endmodule

// File: rtl/serial_eq_arbiter.sv
// Two-requester round-robin front end over one shared serial equality slice.
// Optional EARLY_EXIT_EN: finish as soon as any slice mismatches.
module serial_eq_arbiter
  import serial_eq_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_eq,
  output logic             busy
);

  localparam int NSTEPS = calc_nsteps(WIDTH, BITS_PER_CYCLE);
  localparam int CNTW   = calc_cntw(NSTEPS);

  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of BITS_PER_CYCLE");
  end

  state_t            r_state, w_state_nxt;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [CNTW-1:0]   r_cnt;
  logic              r_id, r_eq, r_last_grant;
  logic              w_gnt, w_accept, w_slice_eq, w_last_step;

  // Tie goes to whoever did not win last; a lone requester always wins.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid) w_gnt = ~r_last_grant;
    else if (req1_valid)          w_gnt = 1'b1;
  end

  assign req0_ready  = (r_state == IDLE) && req0_valid && !w_gnt;
  assign req1_ready  = (r_state == IDLE) && req1_valid &&  w_gnt;
  assign w_accept    = req0_ready || req1_ready;
  assign w_last_step = (r_cnt == CNTW'(NSTEPS - 1));

  eq_slice_cmp #(.W(BITS_PER_CYCLE)) u_slice (
    .i_a  (r_a[BITS_PER_CYCLE-1:0]),
    .i_b  (r_b[BITS_PER_CYCLE-1:0]),
    .o_eq (w_slice_eq)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = RUN;
      RUN: begin
        if (w_last_step) w_state_nxt = DONE;
`ifdef EARLY_EXIT_EN
        if (!w_slice_eq) w_state_nxt = DONE;
`endif
      end
      DONE: if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_cnt        <= '0;
      r_id         <= 1'b0;
      r_eq         <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_accept) begin
          r_a   <= w_gnt ? req1_a : req0_a;
          r_b   <= w_gnt ? req1_b : req0_b;
          r_id  <= w_gnt;
          r_eq  <= 1'b1;
          r_cnt <= '0;
        end
        RUN: begin
          r_eq  <= r_eq & w_slice_eq;
          r_a   <= r_a >> BITS_PER_CYCLE;
          r_b   <= r_b >> BITS_PER_CYCLE;
          r_cnt <= r_cnt + CNTW'(1);
        end
        DONE: if (rsp_ready) r_last_grant <= r_id;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign rsp_id    = r_id;
  assign rsp_eq    = r_eq;
  assign busy      = (r_state != IDLE);

endmodule
